// File: rtl/fuzz_run_controller.sv
// fuzz_run_controller: preload -> DUT reset -> run -> tohost/timeout exit sequencer for one fuzz iteration.
// Optional force_ebreak window is built when FUZZ_RUN_CTRL_EBREAK_FORCE_EN is defined.
module fuzz_run_controller #(
    parameter int RST_W        = 8,
    parameter int FORCE_CYCLES = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [63:0]      cfg_max_cycles,
    input  logic [63:0]      cfg_dump_start,
    input  logic [RST_W-1:0] cfg_reset_cycles,
    output logic             load_req,
    input  logic             load_done,
    output logic             dut_reset,
    input  logic             tohost_valid,
    input  logic [63:0]      tohost_data,
    output logic             dump_en,
    output logic [63:0]      cycle_count,
    output logic             done,
    output logic             pass,
    output logic [62:0]      fail_code,
    output logic             timeout,
    output logic             force_ebreak
);
    typedef enum logic [2:0] {IDLE, LOAD, RESET, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
    logic [63:0]      cycle_count_q, cycle_count_d;
    logic [62:0]      fail_code_q, fail_code_d;
    logic             load_req_q, load_req_d;
    logic             dut_reset_q, dut_reset_d;
    logic             dump_en_q, dump_en_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             timeout_q, timeout_d;
    logic             exit_hit, timeout_hit;
    always_comb begin
        state_d       = state_q;
        rst_cnt_d     = rst_cnt_q;
        cycle_count_d = cycle_count_q;
        fail_code_d   = fail_code_q;
        done_d        = done_q;
        pass_d        = pass_q;
        timeout_d     = timeout_q;
        exit_hit      = tohost_valid && tohost_data[0];
        timeout_hit   = (cfg_max_cycles != 64'd0) && (cycle_count_q == cfg_max_cycles);
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d       = LOAD;
                cycle_count_d = '0;
                fail_code_d   = '0;
                done_d        = 1'b0;
                pass_d        = 1'b0;
                timeout_d     = 1'b0;
            end
            LOAD: if (load_done) begin
                state_d   = RESET;
                rst_cnt_d = (cfg_reset_cycles == '0) ? '0 : cfg_reset_cycles - 1'b1;
            end
            RESET: begin
                state_d   = (rst_cnt_q == '0) ? RUN : RESET;
                rst_cnt_d = (rst_cnt_q == '0) ? rst_cnt_q : rst_cnt_q - 1'b1;
            end
            RUN: if (exit_hit) begin
                // data==1 leaves data[63:1]==0, so fail_code is zero on a pass
                state_d     = DONE;
                done_d      = 1'b1;
                pass_d      = (tohost_data == 64'd1);
                fail_code_d = tohost_data[63:1];
            end else if (timeout_hit) begin
                state_d   = DONE;
                done_d    = 1'b1;
                timeout_d = 1'b1;
            end else begin
                cycle_count_d = (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + 64'd1;
            end
            default: state_d = IDLE;
        endcase
        load_req_d  = (state_d == LOAD);
        dut_reset_d = (state_d != RUN);
        // cycle_count is 0 in RESET, so a zero dump start opens the window on RESET entry
        dump_en_d   = (state_d == RESET || state_d == RUN) && (cycle_count_d >= cfg_dump_start);
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= IDLE;
            rst_cnt_q     <= '0;
            cycle_count_q <= '0;
            fail_code_q   <= '0;
            load_req_q    <= 1'b0;
            dut_reset_q   <= 1'b1;
            dump_en_q     <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rst_cnt_q     <= rst_cnt_d;
            cycle_count_q <= cycle_count_d;
            fail_code_q   <= fail_code_d;
            load_req_q    <= load_req_d;
            dut_reset_q   <= dut_reset_d;
            dump_en_q     <= dump_en_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            timeout_q     <= timeout_d;
        end
    end
`ifdef FUZZ_RUN_CTRL_EBREAK_FORCE_EN
    localparam int FE_W = $clog2(FORCE_CYCLES + 1);
    logic [FE_W-1:0] fe_cnt_q, fe_cnt_d;
    logic            force_ebreak_q, force_ebreak_d;
    always_comb begin
        fe_cnt_d       = fe_cnt_q;
        force_ebreak_d = 1'b0;
        if (state_q == RESET && state_d == RUN) begin
            force_ebreak_d = 1'b1;
            fe_cnt_d       = FE_W'(FORCE_CYCLES - 1);
        end else if (state_q == RUN && state_d == RUN && force_ebreak_q && fe_cnt_q != '0) begin
            force_ebreak_d = 1'b1;
            fe_cnt_d       = fe_cnt_q - 1'b1;
        end
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            fe_cnt_q       <= '0;
            force_ebreak_q <= 1'b0;
        end else begin
            fe_cnt_q       <= fe_cnt_d;
            force_ebreak_q <= force_ebreak_d;
        end
    end
    assign force_ebreak = force_ebreak_q;
`else
    assign force_ebreak = 1'b0;
`endif
    assign load_req    = load_req_q;
    assign dut_reset   = dut_reset_q;
    assign dump_en     = dump_en_q;
    assign cycle_count = cycle_count_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail_code   = fail_code_q;
    assign timeout     = timeout_q;
endmodule

// File: tb/tb_fuzz_run_controller.sv
// tb_fuzz_run_controller: directed runs with a scoreboard of expected run outcomes.
module tb_fuzz_run_controller;
    logic        clock = 0, reset = 0, start = 0, load_done = 0, tohost_valid = 0;
    logic [63:0] cfg_max_cycles = 0, cfg_dump_start = 0, tohost_data = 0;
    logic [7:0]  cfg_reset_cycles = 0;
    logic        load_req, dut_reset, dump_en, done, pass, timeout, force_ebreak;
    logic [63:0] cycle_count;
    logic [62:0] fail_code;
    int total = 0, bad = 0;
`ifdef FUZZ_RUN_CTRL_EBREAK_FORCE_EN
    localparam bit FE_ON = 1'b1;
`else
    localparam bit FE_ON = 1'b0;
`endif
    typedef struct {
        logic        p;
        logic [62:0] fc;
        logic        to;
        logic [63:0] cc;
        int          dump_first;
    } exp_t;
    exp_t sb[$];

    fuzz_run_controller #(.RST_W(8), .FORCE_CYCLES(10)) dut (
        .clock(clock), .reset(reset), .start(start),
        .cfg_max_cycles(cfg_max_cycles), .cfg_dump_start(cfg_dump_start),
        .cfg_reset_cycles(cfg_reset_cycles), .load_req(load_req), .load_done(load_done),
        .dut_reset(dut_reset), .tohost_valid(tohost_valid), .tohost_data(tohost_data),
        .dump_en(dump_en), .cycle_count(cycle_count), .done(done), .pass(pass),
        .fail_code(fail_code), .timeout(timeout), .force_ebreak(force_ebreak)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // rc: reset hold, mx: max cycles, ds: dump start, ex_at/ex_d: exiting tohost,
    // px_at: proxy (even) tohost, ab_at: cycle_count at which reset aborts the run
    task automatic go(input int rc, input int mx, input int ds, input int ex_at,
                      input logic [63:0] ex_d, input int px_at, input int ab_at);
        exp_t e, g;
        int   n, c, low, dump_first, fe_hi, fe_exp;
        logic fe_first;
        if (ex_at >= 0 && ex_d[0] && (mx == 0 || ex_at <= mx)) begin
            e.cc = 64'(ex_at); e.p = (ex_d == 64'd1); e.fc = ex_d[63:1]; e.to = 1'b0;
        end else begin
            e.cc = 64'(mx); e.p = 1'b0; e.fc = '0; e.to = 1'b1;
        end
        e.dump_first = (ds == 0) ? 0 : (64'(ds) <= e.cc) ? ds : -1;
        if (ab_at < 0) sb.push_back(e);
        cfg_reset_cycles = 8'(rc);
        cfg_max_cycles   = 64'(mx);
        cfg_dump_start   = 64'(ds);
        start = 1;
        @(negedge clock);
        start = 0;
        chk("load_req_up", load_req, 1);
        chk("status_cleared", {done, pass, timeout, fail_code}, 0);
        chk("cc_cleared", cycle_count, 0);
        repeat (5) @(negedge clock);
        chk("load_req_held", {load_req, dut_reset}, 2'b11);
        load_done = 1;
        @(negedge clock);
        load_done = 0;
        chk("load_req_drop", load_req, 0);
        chk("dump_on_reset", dump_en, (ds == 0));
        n = 0;
        while (dut_reset && n < 300) begin
            n++;
            @(negedge clock);
        end
        chk("reset_len", n, (rc == 0) ? 1 : rc);
        chk("first_run_cc", cycle_count, 0);
        low = 0; dump_first = -1; fe_hi = 0; fe_first = force_ebreak;
        while (!done && low < 2000) begin
            c = int'(cycle_count);
            if (dump_en && dump_first < 0) dump_first = c;
            if (force_ebreak) fe_hi++;
            if (!dut_reset) low++;
            if (c == ab_at) begin
                reset = 0;
                @(negedge clock);
                reset = 1;
                chk("abort_outs", {dut_reset, done, load_req, dump_en, force_ebreak}, 5'b10000);
                chk("abort_cc", cycle_count, 0);
                return;
            end
            tohost_valid = (c == ex_at) || (c == px_at);
            tohost_data  = (c == ex_at) ? ex_d : 64'h10;
            start        = (c == 20);
            load_done    = (c == 20);
            @(negedge clock);
        end
        tohost_valid = 0; start = 0; load_done = 0;
        chk("done_seen", done, 1);
        if (sb.size() == 0) begin
            chk("sb_nonempty", sb.size(), 1);
            return;
        end
        g = sb.pop_front();
        chk("pass", pass, g.p);
        chk("fail_code", fail_code, g.fc);
        chk("timeout", timeout, g.to);
        chk("cycle_count", cycle_count, g.cc);
        chk("run_span", low, g.cc + 64'd1);
        chk("dump_first", dump_first, g.dump_first);
        chk("done_outs", {dut_reset, dump_en, load_req, force_ebreak}, 4'b1000);
        fe_exp = (low < 10) ? low : 10;
        chk("fe_first", fe_first, FE_ON);
        chk("fe_len", fe_hi, FE_ON ? fe_exp : 0);
        tohost_valid = 1; tohost_data = 64'd5;
        @(negedge clock);
        tohost_valid = 0;
        @(negedge clock);
        chk("held_status", {done, pass, timeout, fail_code}, {1'b1, g.p, g.to, g.fc});
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_outs", {dut_reset, load_req, done, pass, timeout, dump_en, force_ebreak}, 7'b1000000);
        chk("rst_cc", cycle_count, 0);
        chk("rst_fc", fail_code, 0);
        reset = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            chk("idle_hold", {dut_reset, done, load_req}, 3'b100);
        end
        go(4, 0, 1000, 100, 64'd1, -1, -1);
        go(2, 0, 1000, 60, 64'd7, 10, -1);
        go(3, 50, 1000, -1, 64'd0, -1, -1);
        go(1, 50, 1000, 50, 64'd1, -1, -1);
        go(0, 60, 0, -1, 64'd0, 5, -1);
        go(4, 0, 30, 45, 64'd1, -1, -1);
        go(2, 0, 1000, -1, 64'd0, -1, 40);
        go(5, 0, 1000, 70, 64'h8000_0000_0000_0003, -1, -1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fuzz_run_controller.md
Name: fuzz_run_controller

Overview:
- Synthesizable run sequencer for one fuzzing iteration on the CVA6 test harness.
- Sequence: request memory preload, hold the DUT in reset, release it, count cycles, then end the run on a tohost exit or a timeout.
- Reports pass, fail code or timeout status.
- Gates the waveform-dump window.
- Sits between the bench top, the memory loader and the harness reset/tohost nets, replacing the equivalent ad-hoc bench logic.

Parameters:
- RST_W, 8: width of cfg_reset_cycles.
- FORCE_CYCLES, 10: length of the force_ebreak pulse (optional feature only).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low controller reset
- start  in  1  one-cycle run request; honoured only in IDLE or DONE
- cfg_max_cycles  in  64  run-cycle limit; 0 = no timeout
- cfg_dump_start  in  64  run cycle at which dump_en rises
- cfg_reset_cycles  in  RST_W  DUT reset hold length; 0 is treated as 1
- load_req  out  1  level request to the memory preloader
- load_done  in  1  preload-complete pulse or level
- dut_reset  out  1  active-high reset to the harness
- tohost_valid  in  1  DUT wrote tohost this cycle
- tohost_data  in  64  value written to tohost
- dump_en  out  1  waveform dump enable
- cycle_count  out  64  run cycles elapsed
- done  out  1  run finished, status valid
- pass  out  1  exit with tohost == 1
- fail_code  out  63  tohost_data[63:1] on a failing exit
- timeout  out  1  run ended by cfg_max_cycles
- force_ebreak  out  1  debug-CSR force window (optional feature)

Behaviour:
- Reset (reset == 0 at a clock edge) values:
  - state IDLE, dut_reset=1, load_req=0, dump_en=0, cycle_count=0, done=0, pass=0, timeout=0, fail_code=0, force_ebreak=0.
  - Reset is honoured in every state and aborts any run in progress.
- All outputs are registered.
- States:
  - IDLE: dut_reset=1. On start → LOAD. At the transition, clear done, pass, timeout, fail_code and cycle_count.
  - LOAD: load_req=1, dut_reset=1. When load_done is sampled high → RESET, and load_req drops on the same edge. load_done outside LOAD is ignored.
  - RESET: dut_reset=1 for max(cfg_reset_cycles,1) cycles, counted by an internal RST_W counter, then → RUN. cfg_reset_cycles is sampled on entry to RESET.
  - RUN: dut_reset=0. cycle_count increments every RUN cycle, so the first RUN cycle shows 0 and the next shows 1. Exit checks are evaluated each cycle:
    - tohost_valid with tohost_data[0]==1 → DONE. If data==1, pass=1; otherwise pass=0 and fail_code=data[63:1].
    - tohost_valid with tohost_data[0]==0 (proxy syscall) is ignored.
    - If cfg_max_cycles!=0 and cycle_count==cfg_max_cycles with no exiting tohost that cycle → DONE with timeout=1.
    - A valid tohost exit and a timeout in the same cycle: tohost wins, timeout=0.
  - DONE: done=1, dut_reset=1 (freezes the DUT), status held stable. On start → LOAD with status cleared.
- start is ignored in LOAD, RESET and RUN.
- tohost_valid is ignored outside RUN.
- Status latency: done, pass, fail_code and timeout are visible the cycle after the deciding sample.
- dump_en:
  - If cfg_dump_start==0: high from entry to RESET through the end of RUN, so the reset sequence is captured.
  - Otherwise: high in RUN when cycle_count >= cfg_dump_start.
  - Cleared on entry to DONE or IDLE.
- cycle_count saturates at all-ones and never wraps.

Optional Feature:
- Macro: FUZZ_RUN_CTRL_EBREAK_FORCE_EN.
- Defined: force_ebreak rises on the first RUN cycle and stays high for exactly FORCE_CYCLES cycles. The bench uses it to force dcsr.ebreakm/s/u. It drops early on a transition to DONE or on reset.
- Undefined: force_ebreak is tied to 0 and its counter is not instantiated.

Test Plan:
1. Reset low 3 cycles, then high, with no start → dut_reset=1, done=0, load_req=0 held for 20 cycles.
2. cfg_reset_cycles=4, start, load_done 5 cycles later, tohost_valid with data=1 at cycle_count=100 → dut_reset low for exactly the RUN span after 4 reset cycles; done=1, pass=1, cycle_count=100 the next cycle.
3. tohost data=0x0000_0000_0000_0007 → pass=0, fail_code=3. An earlier tohost data=0x10 → ignored, run continues.
4. cfg_max_cycles=50, no tohost → timeout=1, done=1 with cycle_count=50. Repeat with tohost data=1 arriving at cycle_count=50 → pass=1, timeout=0.
5. cfg_dump_start=0 → dump_en rises on RESET entry. cfg_dump_start=30 → dump_en rises when cycle_count=30 and falls on DONE.
6. Reset asserted mid-RUN at cycle_count=40 → next cycle state IDLE, dut_reset=1, cycle_count=0. With FUZZ_RUN_CTRL_EBREAK_FORCE_EN defined, a normal run shows force_ebreak high for exactly 10 cycles from the first RUN cycle.
